aap_fetch_unit: RTL and testbench

- Instruction fetch stage of the AAP pipeline; it is the producer that feeds the 16/32-bit decoder.
- Reads 16-bit words from instruction memory starting at a word-addressed PC.
- Assembles 16-bit or 32-bit instructions and presents them to the decoder with a valid/ready handshake.
- Accepts branch redirects from execute, which flush any partially fetched instruction.

---
 rtl/aap_fetch_unit_if.sv | 28 ++
 rtl/aap_fetch_unit.sv | 95 +++++++++
 tb/tb_aap_fetch_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/aap_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, decoder handshake and execute redirect.
interface aap_fetch_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic [15:0]           imem_rdata;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr_data;
    logic                  instr_is32;
    logic [ADDR_WIDTH-1:0] instr_pc;

    logic                  branch_valid;
    logic [ADDR_WIDTH-1:0] branch_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_data, instr_is32, instr_pc,
        input  imem_ready, imem_rdata, instr_ready, branch_valid, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_data, instr_is32, instr_pc,
        output imem_ready, imem_rdata, instr_ready, branch_valid, branch_target
    );
endinterface

// File: rtl/aap_fetch_unit.sv
// AAP fetch: assembles 16/32-bit instructions from 16-bit words; valid 1 (16b) or 2 (32b) cycles after request.
// Holds the instruction until instr_ready with no prefetch; a redirect flushes any partial or held instruction.
module aap_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic             clock,
    input  logic             reset,
    aap_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH_LO, FETCH_HI, OUT} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  instr_valid;
    logic [31:0]           instr_data;
    logic                  instr_is32;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  mem_hit;

    // Memory data only counts while a request is actually being driven.
    assign mem_hit = imem_req && bus.imem_ready;
    assign pc_next = pc + (instr_is32 ? TWO : ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH_LO;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_is32  <= 1'b0;
            instr_pc    <= RESET_PC;
        end else if (bus.branch_valid) begin
            state       <= FETCH_LO;
            pc          <= bus.branch_target;
            imem_req    <= 1'b1;
            imem_addr   <= bus.branch_target;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH_LO: begin
                    if (mem_hit) begin
                        instr_data <= {16'h0000, bus.imem_rdata};
                        instr_pc   <= pc;
                        instr_is32 <= bus.imem_rdata[15];
                        if (bus.imem_rdata[15]) begin
                            state     <= FETCH_HI;
                            imem_addr <= pc + ONE;
                        end else begin
                            state       <= OUT;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                FETCH_HI: begin
                    if (mem_hit) begin
                        instr_data[31:16] <= bus.imem_rdata;
                        state             <= OUT;
                        imem_req          <= 1'b0;
                        instr_valid       <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.instr_ready) begin
                        state       <= FETCH_LO;
                        pc          <= pc_next;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_next;
                        instr_valid <= 1'b0;
                    end
                end
                default: state <= FETCH_LO;
            endcase
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = imem_addr;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_data  = instr_data;
    assign bus.instr_is32  = instr_is32;
    assign bus.instr_pc    = instr_pc;
endmodule

// File: tb/tb_aap_fetch_unit.sv
// Bench for aap_fetch_unit: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of the instruction stream.
module tb_aap_fetch_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;

    aap_fetch_unit_if #(.ADDR_WIDTH(16)) bus ();

    aap_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:65535];
    assign bus.imem_rdata = mem[bus.imem_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Model: the architectural instruction stream is fully determined by the PC and memory.
    logic [15:0] model_pc  = 16'h0000;
    int          words_got = 0;
    logic        held      = 1'b0;
    int          idle      = 0;

    always @(negedge clock) begin
        logic [15:0] first;
        logic [15:0] second;
        logic [15:0] exp_addr;
        int          len;
        if (reset) begin
            model_pc  = 16'h0000;
            words_got = 0;
            held      = 1'b0;
            idle      = 0;
        end else begin
            first    = mem[model_pc];
            second   = mem[16'(model_pc + 16'd1)];
            len      = first[15] ? 2 : 1;
            exp_addr = 16'(model_pc + 16'(words_got));
            if (bus.imem_req)
                chk("imem_addr", bus.imem_addr, exp_addr);
            if (held)
                chk("hold_valid", bus.instr_valid, 1'b1);
            if (bus.instr_valid) begin
                idle = 0;
                chk("valid_complete", words_got, len);
                chk("req_in_out", bus.imem_req, 1'b0);
                chk("instr_pc", bus.instr_pc, model_pc);
                chk("instr_is32", bus.instr_is32, first[15]);
                chk("instr_data", bus.instr_data, first[15] ? {second, first} : {16'h0000, first});
            end else begin
                idle++;
                if (idle > 64) begin
                    chk("progress_timeout", idle, 64);
                    idle = 0;
                end
            end
            held = bus.instr_valid && !bus.instr_ready && !bus.branch_valid;
            if (bus.branch_valid) begin
                model_pc  = bus.branch_target;
                words_got = 0;
            end else if (bus.instr_valid && bus.instr_ready) begin
                model_pc  = 16'(model_pc + 16'(len));
                words_got = 0;
            end else if (bus.imem_req && bus.imem_ready) begin
                words_got++;
            end
        end
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[0]      = 16'h0012;
        mem[1]      = 16'h0034;
        mem[4]      = 16'h8123;
        mem[5]      = 16'h8456;
        mem[6]      = 16'h9abc;
        mem[7]      = 16'h1357;
        mem[8]      = 16'h8aaa;
        mem[16'h100] = 16'h0042;
        bus.imem_ready    = 1'b1;
        bus.instr_ready   = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 16'h0000;

        repeat (2) cyc();
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_addr", bus.imem_addr, 16'h0000);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_data", bus.instr_data, 32'h0);
        chk("rst_is32", bus.instr_is32, 1'b0);
        chk("rst_pc", bus.instr_pc, 16'h0000);

        // 16-bit stream from reset
        reset = 1'b0;
        cyc();
        chk("c1_req", bus.imem_req, 1'b1);
        chk("c1_valid", bus.instr_valid, 1'b0);
        cyc();
        chk("c2_valid", bus.instr_valid, 1'b1);
        chk("c2_data", bus.instr_data, 32'h0000_0012);
        chk("c2_is32", bus.instr_is32, 1'b0);
        chk("c2_pc", bus.instr_pc, 16'h0000);
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        chk("c3_addr", bus.imem_addr, 16'h0001);
        cyc();
        chk("c4_data", bus.instr_data, 32'h0000_0034);
        chk("c4_pc", bus.instr_pc, 16'h0001);

        // redirect to a 32-bit instruction while a held one is being accepted
        bus.instr_ready   = 1'b1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 16'h0004;
        cyc();
        bus.instr_ready  = 1'b0;
        bus.branch_valid = 1'b0;
        chk("br_valid_drop", bus.instr_valid, 1'b0);
        chk("br_addr", bus.imem_addr, 16'h0004);
        cyc();
        chk("hi_addr", bus.imem_addr, 16'h0005);
        chk("hi_req", bus.imem_req, 1'b1);
        cyc();
        chk("w32_valid", bus.instr_valid, 1'b1);
        chk("w32_data", bus.instr_data, 32'h8456_8123);
        chk("w32_is32", bus.instr_is32, 1'b1);
        chk("w32_pc", bus.instr_pc, 16'h0004);

        // decoder stall
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", bus.instr_valid, 1'b1);
            chk("stall_req", bus.imem_req, 1'b0);
            chk("stall_data", bus.instr_data, 32'h8456_8123);
        end
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        chk("next_addr6", bus.imem_addr, 16'h0006);
        chk("next_req6", bus.imem_req, 1'b1);

        // memory stall on the second word
        cyc();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mstall_addr", bus.imem_addr, 16'h0007);
            chk("mstall_req", bus.imem_req, 1'b1);
            chk("mstall_valid", bus.instr_valid, 1'b0);
            cyc();
        end
        bus.imem_ready = 1'b1;
        cyc();
        chk("mstall_data", bus.instr_data, 32'h1357_9abc);
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;

        // redirect during the second-word fetch
        chk("pre_br_addr", bus.imem_addr, 16'h0008);
        cyc();
        chk("pre_br_hi", bus.imem_addr, 16'h0009);
        bus.branch_valid  = 1'b1;
        bus.branch_target = 16'h0100;
        cyc();
        bus.branch_valid = 1'b0;
        chk("brhi_addr", bus.imem_addr, 16'h0100);
        chk("brhi_valid", bus.instr_valid, 1'b0);
        cyc();
        chk("brhi_data", bus.instr_data, 32'h0000_0042);
        chk("brhi_pc", bus.instr_pc, 16'h0100);

        // reset while holding an instruction
        reset = 1'b1;
        cyc();
        chk("rout_valid", bus.instr_valid, 1'b0);
        chk("rout_addr", bus.imem_addr, 16'h0000);
        chk("rout_req", bus.imem_req, 1'b0);
        mem[0]      = 16'h0002;
        mem[16'hFFFF] = 16'h8001;
        cyc();

        // address wrap on a 32-bit instruction
        reset             = 1'b0;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 16'hFFFF;
        cyc();
        bus.branch_valid = 1'b0;
        chk("wrap_lo", bus.imem_addr, 16'hFFFF);
        cyc();
        chk("wrap_hi", bus.imem_addr, 16'h0000);
        cyc();
        chk("wrap_data", bus.instr_data, 32'h0002_8001);
        chk("wrap_pc", bus.instr_pc, 16'hFFFF);
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        chk("wrap_next", bus.imem_addr, 16'h0001);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset            = ($urandom_range(0, 499) == 0);
            bus.imem_ready   = ($urandom_range(0, 3) != 0);
            bus.instr_ready  = ($urandom_range(0, 1) != 0);
            bus.branch_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.branch_target = 16'hFFFE + 16'($urandom_range(0, 1));
            else
                bus.branch_target = 16'($urandom_range(0, 255));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
